// File: rtl/handshake_slice.sv
// handshake_slice: valid/ready pipeline slice with selectable timing-cut style.
//   MODE 0: pass-through (wires only)
//   MODE 1: forward register (cuts valid/data, ready stays combinational)
//   MODE 2: skid register (cuts ready, valid/data may pass in the same cycle)
//   MODE 3: full two-entry slice (main + skid, every output from a flop)
module handshake_slice #(
   parameter int unsigned DATA_W = 8,
   parameter int          MODE   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_pre_i,
   input  logic [DATA_W-1:0] data_pre_i,
   output logic              ready_pre_o,
   output logic              valid_post_o,
   output logic [DATA_W-1:0] data_post_o,
   input  logic              ready_post_i,
   input  logic              flush_i,
   output logic [1:0]        count_o
);

   // Reject payload widths outside the supported range at elaboration.
   if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_width
      $error("handshake_slice: DATA_W %0d outside 1..1024", DATA_W);
   end

   if (MODE == 0) begin : g_pass
      // Pure wiring; clock, reset and flush have nothing to act on here.
      logic pass_unused;

      assign ready_pre_o  = ready_post_i;
      assign valid_post_o = valid_pre_i;
      assign data_post_o  = data_pre_i;
      assign count_o      = 2'd0;
      assign pass_unused  = ^{clk, rst_n, flush_i};

   end else if (MODE == 1) begin : g_fwd
      logic              v_q;
      logic              v_d;
      logic [DATA_W-1:0] d_q;
      logic [DATA_W-1:0] d_d;
      logic              enq_c;
      logic              deq_c;

      // The register can take a new beat when empty or when it is draining now.
      assign ready_pre_o  = !v_q || ready_post_i;
      assign valid_post_o = v_q;
      assign data_post_o  = d_q;
      assign count_o      = {1'b0, v_q};

      // Next state: flush wins, then load on enqueue, else clear on dequeue.
      always_comb begin
         v_d   = v_q;
         d_d   = d_q;
         enq_c = valid_pre_i && ready_pre_o;
         deq_c = v_q && ready_post_i;
         if (flush_i) begin
            v_d = 1'b0;
         end else if (enq_c) begin
            v_d = 1'b1;
            d_d = data_pre_i;
         end else if (deq_c) begin
            v_d = 1'b0;
         end
      end

      // Forward register state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
         end else begin
            v_q <= v_d;
            d_q <= d_d;
         end
      end

   end else if (MODE == 2) begin : g_skid
      logic              s_v_q;
      logic              s_v_d;
      logic [DATA_W-1:0] s_d_q;
      logic [DATA_W-1:0] s_d_d;
      logic              capture_c;
      logic              release_c;

      // Ready comes straight from the skid flag; data bypasses when skid is empty.
      assign ready_pre_o  = !s_v_q;
      assign valid_post_o = valid_pre_i || s_v_q;
      assign data_post_o  = s_v_q ? s_d_q : data_pre_i;
      assign count_o      = {1'b0, s_v_q};

      // Catch a real beat that was accepted but not taken downstream; drain on ready.
      always_comb begin
         s_v_d     = s_v_q;
         s_d_d     = s_d_q;
         capture_c = valid_pre_i && !s_v_q && !ready_post_i;
         release_c = s_v_q && ready_post_i;
         if (flush_i) begin
            s_v_d = 1'b0;
         end else if (capture_c) begin
            s_v_d = 1'b1;
            s_d_d = data_pre_i;
         end else if (release_c) begin
            s_v_d = 1'b0;
         end
      end

      // Skid register state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_v_q <= 1'b0;
            s_d_q <= '0;
         end else begin
            s_v_q <= s_v_d;
            s_d_q <= s_d_d;
         end
      end

   end else if (MODE == 3) begin : g_full
      logic              m_v_q;
      logic              m_v_d;
      logic [DATA_W-1:0] m_d_q;
      logic [DATA_W-1:0] m_d_d;
      logic              s_v_q;
      logic              s_v_d;
      logic [DATA_W-1:0] s_d_q;
      logic [DATA_W-1:0] s_d_d;
      logic              enq_c;
      logic              deq_c;
      logic              main_free_c;

      // Every output is a flop or a single inverter on a flop.
      assign ready_pre_o  = !s_v_q;
      assign valid_post_o = m_v_q;
      assign data_post_o  = m_d_q;
      assign count_o      = {1'b0, m_v_q} + {1'b0, s_v_q};

      // Main refills from skid first to keep order; skid absorbs a beat while main stalls.
      always_comb begin
         m_v_d       = m_v_q;
         m_d_d       = m_d_q;
         s_v_d       = s_v_q;
         s_d_d       = s_d_q;
         enq_c       = valid_pre_i && !s_v_q;
         deq_c       = m_v_q && ready_post_i;
         main_free_c = deq_c || !m_v_q;
         if (flush_i) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
         end else if (main_free_c) begin
            if (s_v_q) begin
               m_v_d = 1'b1;
               m_d_d = s_d_q;
               s_v_d = 1'b0;
            end else if (enq_c) begin
               m_v_d = 1'b1;
               m_d_d = data_pre_i;
            end else begin
               m_v_d = 1'b0;
            end
         end else if (enq_c) begin
            s_v_d = 1'b1;
            s_d_d = data_pre_i;
         end
      end

      // Main and skid register state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_v_q <= 1'b0;
            m_d_q <= '0;
            s_v_q <= 1'b0;
            s_d_q <= '0;
         end else begin
            m_v_q <= m_v_d;
            m_d_q <= m_d_d;
            s_v_q <= s_v_d;
            s_d_q <= s_d_d;
         end
      end

      // The skid entry is only ever occupied behind a full main register.
      a_skid_behind_main: assert property (@(posedge clk) disable iff (!rst_n) s_v_q |-> m_v_q);

   end else begin : g_bad_mode
      $error("handshake_slice: MODE %0d is not one of 0..3", MODE);
   end

endmodule

// File: tb/tb_handshake_slice.sv
// Bench for handshake_slice: twelve instances (MODE 0..3 x DATA_W 1/8/64),
// directed scenarios on the 8-bit instances plus a randomised scoreboard run on all.
module tb_handshake_slice;

   localparam int N           = 12;
   localparam int RAND_CYCLES = 3000;
   // Instance index = width_slot*4 + mode; width slot 1 is DATA_W=8.
   localparam int K0 = 4;
   localparam int K1 = 5;
   localparam int K2 = 6;
   localparam int K3 = 7;

   logic        clk;
   logic        rst_n;
   logic        vp  [N];
   logic        rp  [N];
   logic        fl  [N];
   logic [63:0] dp  [N];
   logic        rdy [N];
   logic        vq  [N];
   logic [63:0] dq  [N];
   logic [1:0]  cnt [N];
   logic [63:0] sb_q[N][$];

   int unsigned vectors;
   int unsigned miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gw = 0; gw < 3; gw++) begin : g_w
      for (genvar gm = 0; gm < 4; gm++) begin : g_m
         localparam int          K = gw * 4 + gm;
         localparam int unsigned W = (gw == 0) ? 1 : (gw == 1) ? 8 : 64;
         logic [W-1:0] d_out;

         handshake_slice #(.DATA_W(W), .MODE(gm)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .valid_pre_i  (vp[K]),
            .data_pre_i   (dp[K][W-1:0]),
            .ready_pre_o  (rdy[K]),
            .valid_post_o (vq[K]),
            .data_post_o  (d_out),
            .ready_post_i (rp[K]),
            .flush_i      (fl[K]),
            .count_o      (cnt[K])
         );
         assign dq[K] = 64'(d_out);
      end
   end

   function automatic int mode_of(int k);
      return k % 4;
   endfunction

   function automatic logic [63:0] mask_of(int k);
      if (k < 4) return 64'h1;
      if (k < 8) return 64'hFF;
      return '1;
   endfunction

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         vp[k] = 1'b0;
         rp[k] = 1'b0;
         fl[k] = 1'b0;
         dp[k] = '0;
      end
   endtask

   // Reset values on every instance, held across clock edges with valid asserted.
   task automatic test_reset();
      logic        exp_v;
      logic        exp_r;
      logic [63:0] exp_d;
      int          m;
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         vp[k] = 1'b1;
         rp[k] = 1'b0;
         fl[k] = 1'b0;
         dp[k] = 64'hA5C3_0F96_1234_5679 & mask_of(k);
      end
      for (int pass = 0; pass < 2; pass++) begin
         #1;
         for (int k = 0; k < N; k++) begin
            m     = mode_of(k);
            exp_v = (m == 0 || m == 2);
            exp_r = (m == 0) ? rp[k] : 1'b1;
            exp_d = (m == 0 || m == 2) ? (dp[k] & mask_of(k)) : 64'd0;
            vectors++;
            if (vq[k] !== exp_v) begin
               miscompares++;
               $display("FAIL reset_valid k=%0d got %b exp %b", k, vq[k], exp_v);
            end
            vectors++;
            if (rdy[k] !== exp_r) begin
               miscompares++;
               $display("FAIL reset_ready k=%0d got %b exp %b", k, rdy[k], exp_r);
            end
            vectors++;
            if (cnt[k] !== 2'd0) begin
               miscompares++;
               $display("FAIL reset_count k=%0d got %0d exp 0", k, cnt[k]);
            end
            vectors++;
            if (dq[k] !== exp_d) begin
               miscompares++;
               $display("FAIL reset_data k=%0d got %h exp %h", k, dq[k], exp_d);
            end
         end
         repeat (2) @(negedge clk);
      end
      idle_all();
      rst_n = 1'b1;
   endtask

   // MODE 3 streaming at full rate: one cycle latency, count stays 1.
   task automatic test_stream();
      logic [63:0] exp;
      rp[K3] = 1'b1;
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         vp[K3] = (c < 16);
         dp[K3] = 64'(c + 1);
         #1;
         if (c < 16) begin
            vectors++;
            if (rdy[K3] !== 1'b1) begin
               miscompares++;
               $display("FAIL stream_ready c=%0d got %b exp 1", c, rdy[K3]);
            end
            sb_q[K3].push_back(dp[K3]);
         end
         if (c == 0 || c == 17) begin
            vectors++;
            if (vq[K3] !== 1'b0 || cnt[K3] !== 2'd0) begin
               miscompares++;
               $display("FAIL stream_idle c=%0d got v=%b n=%0d exp v=0 n=0", c, vq[K3], cnt[K3]);
            end
         end else begin
            exp = sb_q[K3].size() > 0 ? sb_q[K3].pop_front() : 64'hDEAD;
            vectors++;
            if (vq[K3] !== 1'b1 || dq[K3] !== exp || cnt[K3] !== 2'd1) begin
               miscompares++;
               $display("FAIL stream_out c=%0d got v=%b d=%h n=%0d exp v=1 d=%h n=1",
                        c, vq[K3], dq[K3], cnt[K3], exp);
            end
         end
      end
      idle_all();
   endtask

   // MODE 3 backpressure: two beats held, third stalled, order kept after release.
   task automatic test_backpressure();
      logic [63:0] beats[3];
      logic [63:0] exp;
      int          nxt;
      int          got;
      beats[0] = 64'hA1;
      beats[1] = 64'hA2;
      beats[2] = 64'hA3;
      nxt = 0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rp[K3] = (c >= 4);
         vp[K3] = (nxt < 3);
         dp[K3] = (nxt < 3) ? beats[nxt] : 64'd0;
         #1;
         if (c == 2 || c == 3) begin
            vectors++;
            if (cnt[K3] !== 2'd2 || rdy[K3] !== 1'b0 || vq[K3] !== 1'b1 || dq[K3] !== 64'hA1) begin
               miscompares++;
               $display("FAIL bp_full c=%0d got n=%0d r=%b v=%b d=%h exp n=2 r=0 v=1 d=a1",
                        c, cnt[K3], rdy[K3], vq[K3], dq[K3]);
            end
         end
         if (vp[K3] && rdy[K3]) begin
            sb_q[K3].push_back(dp[K3]);
            nxt++;
         end
         if (vq[K3] && rp[K3]) begin
            exp = sb_q[K3].size() > 0 ? sb_q[K3].pop_front() : 64'hDEAD;
            got++;
            vectors++;
            if (dq[K3] !== exp) begin
               miscompares++;
               $display("FAIL bp_order c=%0d got %h exp %h", c, dq[K3], exp);
            end
         end
      end
      vectors++;
      if (got != 3 || sb_q[K3].size() != 0) begin
         miscompares++;
         $display("FAIL bp_total got %0d beats exp 3 (left %0d)", got, sb_q[K3].size());
      end
      idle_all();
   endtask

   // MODE 2: bubbles are never captured; a beat passes through in its own cycle.
   task automatic test_bubble();
      rp[K2] = 1'b0;
      vp[K2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (rdy[K2] !== 1'b1 || cnt[K2] !== 2'd0 || vq[K2] !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_idle c=%0d got r=%b n=%0d v=%b exp r=1 n=0 v=0",
                     c, rdy[K2], cnt[K2], vq[K2]);
         end
      end
      @(negedge clk);
      vp[K2] = 1'b1;
      dp[K2] = 64'h5C;
      rp[K2] = 1'b1;
      #1;
      vectors++;
      if (vq[K2] !== 1'b1 || dq[K2] !== 64'h5C || rdy[K2] !== 1'b1) begin
         miscompares++;
         $display("FAIL bubble_pass got v=%b d=%h r=%b exp v=1 d=5c r=1", vq[K2], dq[K2], rdy[K2]);
      end
      @(negedge clk);
      vp[K2] = 1'b1;
      dp[K2] = 64'h77;
      rp[K2] = 1'b0;
      #1;
      vectors++;
      if (cnt[K2] !== 2'd0 || vq[K2] !== 1'b1 || dq[K2] !== 64'h77) begin
         miscompares++;
         $display("FAIL skid_offer got n=%0d v=%b d=%h exp n=0 v=1 d=77", cnt[K2], vq[K2], dq[K2]);
      end
      @(negedge clk);
      vp[K2] = 1'b0;
      dp[K2] = 64'h00;
      #1;
      vectors++;
      if (cnt[K2] !== 2'd1 || rdy[K2] !== 1'b0 || vq[K2] !== 1'b1 || dq[K2] !== 64'h77) begin
         miscompares++;
         $display("FAIL skid_hold got n=%0d r=%b v=%b d=%h exp n=1 r=0 v=1 d=77",
                  cnt[K2], rdy[K2], vq[K2], dq[K2]);
      end
      rp[K2] = 1'b1;
      @(negedge clk);
      rp[K2] = 1'b0;
      #1;
      vectors++;
      if (cnt[K2] !== 2'd0 || vq[K2] !== 1'b0 || rdy[K2] !== 1'b1) begin
         miscompares++;
         $display("FAIL skid_release got n=%0d v=%b r=%b exp n=0 v=0 r=1", cnt[K2], vq[K2], rdy[K2]);
      end
      idle_all();
   endtask

   // Flush in every mode: clears held beats, discards same-cycle enqueue, ignored in MODE 0.
   task automatic test_flush();
      // MODE 1
      @(negedge clk);
      vp[K1] = 1'b1;
      dp[K1] = 64'h3E;
      @(negedge clk);
      dp[K1] = 64'h3F;
      fl[K1] = 1'b1;
      #1;
      vectors++;
      if (vq[K1] !== 1'b1 || dq[K1] !== 64'h3E || cnt[K1] !== 2'd1 || rdy[K1] !== 1'b0) begin
         miscompares++;
         $display("FAIL flush1_during got v=%b d=%h n=%0d r=%b exp v=1 d=3e n=1 r=0",
                  vq[K1], dq[K1], cnt[K1], rdy[K1]);
      end
      @(negedge clk);
      vp[K1] = 1'b0;
      fl[K1] = 1'b0;
      rp[K1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (vq[K1] !== 1'b0 || cnt[K1] !== 2'd0 || rdy[K1] !== 1'b1) begin
            miscompares++;
            $display("FAIL flush1_after c=%0d got v=%b n=%0d r=%b exp v=0 n=0 r=1",
                     c, vq[K1], cnt[K1], rdy[K1]);
         end
         @(negedge clk);
      end
      // MODE 3: flush with both entries full and a delivering dequeue
      rp[K3] = 1'b0;
      vp[K3] = 1'b1;
      dp[K3] = 64'h11;
      @(negedge clk);
      dp[K3] = 64'h22;
      @(negedge clk);
      vp[K3] = 1'b0;
      rp[K3] = 1'b1;
      fl[K3] = 1'b1;
      #1;
      vectors++;
      if (vq[K3] !== 1'b1 || dq[K3] !== 64'h11 || cnt[K3] !== 2'd2) begin
         miscompares++;
         $display("FAIL flush3_during got v=%b d=%h n=%0d exp v=1 d=11 n=2", vq[K3], dq[K3], cnt[K3]);
      end
      @(negedge clk);
      rp[K3] = 1'b0;
      vp[K3] = 1'b1;
      dp[K3] = 64'h99;
      #1;
      vectors++;
      if (vq[K3] !== 1'b0 || cnt[K3] !== 2'd0 || rdy[K3] !== 1'b1) begin
         miscompares++;
         $display("FAIL flush3_clear got v=%b n=%0d r=%b exp v=0 n=0 r=1", vq[K3], cnt[K3], rdy[K3]);
      end
      @(negedge clk);
      fl[K3] = 1'b0;
      dp[K3] = 64'h42;
      #1;
      vectors++;
      if (vq[K3] !== 1'b0 || cnt[K3] !== 2'd0) begin
         miscompares++;
         $display("FAIL flush3_discard got v=%b n=%0d exp v=0 n=0", vq[K3], cnt[K3]);
      end
      @(negedge clk);
      vp[K3] = 1'b0;
      #1;
      vectors++;
      if (vq[K3] !== 1'b1 || dq[K3] !== 64'h42 || cnt[K3] !== 2'd1) begin
         miscompares++;
         $display("FAIL flush3_next got v=%b d=%h n=%0d exp v=1 d=42 n=1", vq[K3], dq[K3], cnt[K3]);
      end
      rp[K3] = 1'b1;
      // MODE 2: flush a captured skid beat
      vp[K2] = 1'b1;
      dp[K2] = 64'h33;
      @(negedge clk);
      rp[K3] = 1'b0;
      vp[K2] = 1'b0;
      fl[K2] = 1'b1;
      #1;
      vectors++;
      if (cnt[K2] !== 2'd1 || vq[K2] !== 1'b1 || dq[K2] !== 64'h33) begin
         miscompares++;
         $display("FAIL flush2_during got n=%0d v=%b d=%h exp n=1 v=1 d=33", cnt[K2], vq[K2], dq[K2]);
      end
      @(negedge clk);
      fl[K2] = 1'b0;
      #1;
      vectors++;
      if (cnt[K2] !== 2'd0 || vq[K2] !== 1'b0 || rdy[K2] !== 1'b1 || cnt[K3] !== 2'd0) begin
         miscompares++;
         $display("FAIL flush2_after got n=%0d v=%b r=%b n3=%0d exp n=0 v=0 r=1 n3=0",
                  cnt[K2], vq[K2], rdy[K2], cnt[K3]);
      end
      // MODE 0: flush has no effect
      fl[K0] = 1'b1;
      vp[K0] = 1'b1;
      dp[K0] = 64'h12;
      rp[K0] = 1'b1;
      #1;
      vectors++;
      if (vq[K0] !== 1'b1 || dq[K0] !== 64'h12 || rdy[K0] !== 1'b1 || cnt[K0] !== 2'd0) begin
         miscompares++;
         $display("FAIL flush0_ignored got v=%b d=%h r=%b n=%0d exp v=1 d=12 r=1 n=0",
                  vq[K0], dq[K0], rdy[K0], cnt[K0]);
      end
      @(negedge clk);
      idle_all();
   endtask

   // MODE 3 reset pulse between edges with two beats held.
   task automatic test_reset_mid();
      @(negedge clk);
      vp[K3] = 1'b1;
      dp[K3] = 64'hB1;
      @(negedge clk);
      dp[K3] = 64'hB2;
      @(negedge clk);
      vp[K3] = 1'b0;
      #1;
      vectors++;
      if (cnt[K3] !== 2'd2) begin
         miscompares++;
         $display("FAIL rstmid_pre got n=%0d exp 2", cnt[K3]);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (cnt[K3] !== 2'd0 || vq[K3] !== 1'b0 || dq[K3] !== 64'd0 || rdy[K3] !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_now got n=%0d v=%b d=%h r=%b exp n=0 v=0 d=00 r=1",
                  cnt[K3], vq[K3], dq[K3], rdy[K3]);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < N; k++) sb_q[k].delete();
      @(negedge clk);
      #1;
      vectors++;
      if (cnt[K3] !== 2'd0 || vq[K3] !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_empty got n=%0d v=%b exp n=0 v=0", cnt[K3], vq[K3]);
      end
      vp[K3] = 1'b1;
      dp[K3] = 64'hC1;
      rp[K3] = 1'b1;
      @(negedge clk);
      vp[K3] = 1'b0;
      #1;
      vectors++;
      if (vq[K3] !== 1'b1 || dq[K3] !== 64'hC1 || cnt[K3] !== 2'd1) begin
         miscompares++;
         $display("FAIL rstmid_restart got v=%b d=%h n=%0d exp v=1 d=c1 n=1", vq[K3], dq[K3], cnt[K3]);
      end
      @(negedge clk);
      idle_all();
   endtask

   // Random valid/ready on all instances; scoreboard order, occupancy and output stability.
   task automatic test_random();
      logic        stall [N];
      logic        hold_v[N];
      logic [63:0] hold_d[N];
      logic [63:0] exp;
      for (int k = 0; k < N; k++) begin
         stall[k]  = 1'b0;
         hold_v[k] = 1'b0;
         hold_d[k] = '0;
      end
      for (int c = 0; c < RAND_CYCLES + 20; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (!stall[k]) begin
               vp[k] = (c < RAND_CYCLES) ? 1'($urandom_range(0, 1)) : 1'b0;
               dp[k] = {$urandom, $urandom} & mask_of(k);
            end
            rp[k] = (c < RAND_CYCLES) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         #1;
         for (int k = 0; k < N; k++) begin
            if (hold_v[k]) begin
               vectors++;
               if (vq[k] !== 1'b1 || dq[k] !== hold_d[k]) begin
                  miscompares++;
                  $display("FAIL rand_stable k=%0d c=%0d got v=%b d=%h exp v=1 d=%h",
                           k, c, vq[k], dq[k], hold_d[k]);
               end
            end
            vectors++;
            if (cnt[k] !== 2'(sb_q[k].size())) begin
               miscompares++;
               $display("FAIL rand_count k=%0d c=%0d got %0d exp %0d", k, c, cnt[k], sb_q[k].size());
            end
            if (vp[k] && rdy[k]) sb_q[k].push_back(dp[k]);
            if (vq[k] && rp[k]) begin
               vectors++;
               if (sb_q[k].size() == 0) begin
                  miscompares++;
                  $display("FAIL rand_spurious k=%0d c=%0d got %h exp no beat", k, c, dq[k]);
               end else begin
                  exp = sb_q[k].pop_front();
                  if (dq[k] !== exp) begin
                     miscompares++;
                     $display("FAIL rand_data k=%0d c=%0d got %h exp %h", k, c, dq[k], exp);
                  end
               end
            end
            stall[k]  = vp[k] && !rdy[k];
            hold_v[k] = vq[k] && !rp[k];
            hold_d[k] = dq[k];
         end
      end
      for (int k = 0; k < N; k++) begin
         vectors++;
         if (sb_q[k].size() != 0 || vq[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain k=%0d got %0d left v=%b exp 0 left v=0", k, sb_q[k].size(), vq[k]);
         end
      end
      idle_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      idle_all();
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
